// File: rtl/arith_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_seq_if
//  Description : Operand/opcode/handshake bundle between operand entry logic
//                (master) and the arith_unit_seq unit (slave). The acc and
//                acc_ovf signals exist only when ARTH_ACC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface arith_unit_seq_if #(
   parameter int WIDTH     = 4,
   parameter int OUT_WIDTH = 16
);
   logic [WIDTH-1:0]     V1;
   logic [WIDTH-1:0]     V2;
   logic [1:0]           opcode;
   logic                 newop;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [OUT_WIDTH-1:0] ans;
`ifdef ARTH_ACC_EN
   logic                 acc;
   logic                 acc_ovf;

   modport master (output V1, V2, opcode, newop, start, acc,
                   input  busy, done, ans, acc_ovf);
   modport slave  (input  V1, V2, opcode, newop, start, acc,
                   output busy, done, ans, acc_ovf);
`else
   modport master (output V1, V2, opcode, newop, start,
                   input  busy, done, ans);
   modport slave  (input  V1, V2, opcode, newop, start,
                   output busy, done, ans);
`endif
endinterface
`default_nettype wire

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_seq
//  Description : Add / subtract (1-cycle) and iterative shift-add unsigned or
//                signed multiply with start/done handshake and a registered
//                result. Optional accumulate mode enabled by macro ARTH_ACC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_seq #(
   parameter int WIDTH     = 4,
   parameter int OUT_WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   arith_unit_seq_if.slave  bus
);

   localparam int c_pw    = 2 * WIDTH;
   localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_opcode;
   logic [1:0]           w_op;
   logic                 w_idle;
   logic [WIDTH-1:0]     w_mag1;
   logic [WIDTH-1:0]     w_mag2;
   logic [c_pw-1:0]      r_mcand;
   logic [c_pw-1:0]      r_prod;
   logic [c_pw-1:0]      w_prod_fix;
   logic [WIDTH-1:0]     r_mplier;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_neg;
   logic                 r_signed;
   logic                 r_done;
   logic [OUT_WIDTH-1:0] r_ans;
   logic [OUT_WIDTH-1:0] w_v1x;
   logic [OUT_WIDTH-1:0] w_v2x;
   logic [OUT_WIDTH-1:0] w_addsub;
   logic [OUT_WIDTH-1:0] w_mulres;
   logic [OUT_WIDTH-1:0] w_result;
   logic [OUT_WIDTH-1:0] w_ans_nxt;

   assign w_idle = (r_state == S_IDLE);

   // A newop in the same idle cycle as start applies to that operation
   assign w_op = (w_idle && bus.newop) ? bus.opcode : r_opcode;

   // Add/sub on sign-extended operands; subtract is V2 - V1
   assign w_v1x    = OUT_WIDTH'($signed(bus.V1));
   assign w_v2x    = OUT_WIDTH'($signed(bus.V2));
   assign w_addsub = w_op[1] ? (w_v2x - w_v1x) : (w_v1x + w_v2x);

   // Signed multiply works on magnitudes; -2^(WIDTH-1) maps to an unsigned
   // WIDTH-bit magnitude of 2^(WIDTH-1), so no extra bit is needed
   assign w_mag1 = (w_op[1] && bus.V1[WIDTH-1]) ? (~bus.V1 + WIDTH'(1)) : bus.V1;
   assign w_mag2 = (w_op[1] && bus.V2[WIDTH-1]) ? (~bus.V2 + WIDTH'(1)) : bus.V2;

   // Re-apply the sign and extend: sign-extend for signed, zero for unsigned
   assign w_prod_fix = r_neg ? (~r_prod + c_pw'(1)) : r_prod;
   assign w_mulres   = r_signed ? OUT_WIDTH'($signed(w_prod_fix)) : OUT_WIDTH'(w_prod_fix);

   assign w_result = (r_state == S_DONE) ? w_mulres : w_addsub;

`ifdef ARTH_ACC_EN
   logic                 r_acc;
   logic                 r_acc_ovf;
   logic                 w_acc_sel;
   logic                 w_ovf;
   logic [OUT_WIDTH-1:0] w_sum;

   // Accumulate flag is taken live for add/sub, latched for multiply
   assign w_acc_sel = w_idle ? bus.acc : r_acc;
   assign w_sum     = r_ans + w_result;
   assign w_ovf     = (r_ans[OUT_WIDTH-1] == w_result[OUT_WIDTH-1]) &&
                      (w_sum[OUT_WIDTH-1] != r_ans[OUT_WIDTH-1]);
   assign w_ans_nxt = w_acc_sel ? w_sum : w_result;
   assign bus.acc_ovf = r_acc_ovf;
`else
   assign w_ans_nxt = w_result;
`endif

   assign bus.busy = (r_state == S_MUL);
   assign bus.done = r_done;
   assign bus.ans  = r_ans;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: only multiplies leave IDLE; MUL runs WIDTH iterations
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start && w_op[0]) w_state_nxt = S_MUL;
         S_MUL:   if (r_cnt == c_last)      w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: opcode register, shift-add iteration, result and done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         r_opcode <= 2'b00;
         r_done   <= 1'b0;
         r_ans    <= '0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_signed <= 1'b0;
`ifdef ARTH_ACC_EN
         r_acc     <= 1'b0;
         r_acc_ovf <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_idle && bus.newop) r_opcode <= bus.opcode;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
`ifdef ARTH_ACC_EN
                  r_acc <= bus.acc;
                  if (!bus.acc) r_acc_ovf <= 1'b0;
`endif
                  if (w_op[0]) begin
                     r_mcand  <= c_pw'(w_mag1);
                     r_mplier <= w_mag2;
                     r_prod   <= '0;
                     r_cnt    <= '0;
                     r_neg    <= w_op[1] & (bus.V1[WIDTH-1] ^ bus.V2[WIDTH-1]);
                     r_signed <= w_op[1];
                  end else begin
                     r_ans  <= w_ans_nxt;
                     r_done <= 1'b1;
`ifdef ARTH_ACC_EN
                     if (bus.acc && w_ovf) r_acc_ovf <= 1'b1;
`endif
                  end
               end
            end
            S_MUL: begin
               if (r_mplier[0]) r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + c_cnt_w'(1);
            end
            S_DONE: begin
               r_ans  <= w_ans_nxt;
               r_done <= 1'b1;
`ifdef ARTH_ACC_EN
               if (r_acc && w_ovf) r_acc_ovf <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_unit_seq
//  Description : Scoreboard testbench for arith_unit_seq (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_seq;

   localparam int WIDTH     = 4;
   localparam int OUT_WIDTH = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   arith_unit_seq_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

   arith_unit_seq #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int                   n_checks = 0;
   int                   n_errors = 0;
   logic [OUT_WIDTH-1:0] exp_q[$];
   logic [1:0]           model_op  = 2'b00;
   logic [OUT_WIDTH-1:0] model_ans = '0;
   logic                 model_ovf = 1'b0;
   logic                 acc_mode  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on plain integers
   function automatic logic [OUT_WIDTH-1:0] model_result(input logic [1:0] op,
                                                         input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
      int sa, sb, ua, ub, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      case (op)
         2'b00:   r = sa + sb;
         2'b01:   r = ua * ub;
         2'b10:   r = sb - sa;
         default: r = sa * sb;
      endcase
      return OUT_WIDTH'(r);
   endfunction

   task automatic push_expect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [OUT_WIDTH-1:0] res, sum;
      res = model_result(model_op, a, b);
      if (acc_mode) begin
         sum = model_ans + res;
         if ((model_ans[OUT_WIDTH-1] == res[OUT_WIDTH-1]) && (sum[OUT_WIDTH-1] != model_ans[OUT_WIDTH-1]))
            model_ovf = 1'b1;
         model_ans = sum;
      end else begin
         model_ovf = 1'b0;
         model_ans = res;
      end
      exp_q.push_back(model_ans);
   endtask

   // Wait (bounded) for done; returns at the negedge where done is seen
   task automatic wait_done(input string tag, input int exp_busy);
      int  busy_cnt;
      bit  seen;
      busy_cnt = 0;
      seen     = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            seen = 1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (!seen) exp_q.delete();
      if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
`ifdef ARTH_ACC_EN
      check({tag, "_acc_ovf"}, 32'(bus.acc_ovf), 32'(model_ovf));
`endif
   endtask

   // Drive one operation starting now; start is held for exactly one edge
   task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit load, input int exp_busy, input string tag);
      bus.opcode = op;
      bus.newop  = load;
      bus.start  = 1'b1;
      bus.V1     = a;
      bus.V2     = b;
`ifdef ARTH_ACC_EN
      bus.acc    = acc_mode;
`endif
      if (load) model_op = op;
      push_expect(a, b);
      @(posedge clock);
      #1;
      bus.newop = 1'b0;
      bus.start = 1'b0;
      bus.V1    = WIDTH'($urandom);
      bus.V2    = WIDTH'($urandom);
      wait_done(tag, exp_busy);
   endtask

   // Scoreboard: every done pops one expectation
   always @(negedge clock) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
         else                   check("ans", 32'(bus.ans), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      logic [1:0] rop;

      bus.V1     = '0;
      bus.V2     = '0;
      bus.opcode = 2'b00;
      bus.newop  = 1'b0;
      bus.start  = 1'b0;
`ifdef ARTH_ACC_EN
      bus.acc    = 1'b0;
`endif
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ans",  32'(bus.ans),  32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Add / subtract
      do_op(2'b00, 4'h3, 4'hE, 1'b1, 0, "add");
      @(negedge clock);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      do_op(2'b10, 4'h5, 4'h2, 1'b1, 0, "sub");

      // Multiplies, including most-negative operands
      do_op(2'b01, 4'hF, 4'hF, 1'b1, WIDTH, "umul_ff");
      do_op(2'b11, 4'h8, 4'h3, 1'b1, WIDTH, "smul_8_3");
      do_op(2'b11, 4'h8, 4'h8, 1'b1, WIDTH, "smul_8_8");
      do_op(2'b11, 4'h7, 4'h8, 1'b1, WIDTH, "smul_7_8");
      do_op(2'b11, 4'hF, 4'hF, 1'b1, WIDTH, "smul_f_f");
      // Issued in the done cycle of the previous multiply
      do_op(2'b00, 4'h7, 4'h7, 1'b1, 0, "b2b_add");

      // start/newop during a multiply are ignored
      bus.opcode = 2'b01;
      bus.newop  = 1'b1;
      bus.start  = 1'b1;
      bus.V1     = 4'h3;
      bus.V2     = 4'h5;
      model_op   = 2'b01;
      push_expect(4'h3, 4'h5);
      @(posedge clock);
      #1;
      bus.newop  = 1'b0;
      bus.start  = 1'b0;
      @(posedge clock);
      #1;
      bus.V1     = 4'h1;
      bus.V2     = 4'h1;
      bus.opcode = 2'b00;
      bus.newop  = 1'b1;
      bus.start  = 1'b1;
      @(posedge clock);
      #1;
      bus.newop  = 1'b0;
      bus.start  = 1'b0;
      wait_done("busy_ignore", -1);
      do_op(2'b00, 4'h2, 4'h3, 1'b0, WIDTH, "opcode_kept");

      // Reset in the second MUL cycle aborts with no done
      @(negedge clock);
      bus.opcode = 2'b01;
      bus.newop  = 1'b1;
      bus.start  = 1'b1;
      bus.V1     = 4'hF;
      bus.V2     = 4'hF;
      @(posedge clock);
      #1;
      bus.newop  = 1'b0;
      bus.start  = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ans",  32'(bus.ans),  32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      model_op  = 2'b00;
      model_ans = '0;
      model_ovf = 1'b0;
      n_done = 0;
      repeat (8) begin
         @(negedge clock);
         if (bus.done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      // Opcode register returned to add by reset
      do_op(2'b11, 4'h2, 4'h3, 1'b0, 0, "opcode_after_rst");

      // Random mix
      for (int i = 0; i < 16; i++) begin
         rop = 2'($urandom_range(0, 3));
         do_op(rop, WIDTH'($urandom), WIDTH'($urandom), 1'b1, rop[0] ? WIDTH : 0, "rand");
      end

`ifdef ARTH_ACC_EN
      acc_mode = 1'b0;
      do_op(2'b01, 4'hF, 4'hF, 1'b1, WIDTH, "acc_base");
      acc_mode = 1'b1;
      for (int i = 0; i < 145; i++)
         do_op(2'b01, 4'hF, 4'hF, 1'b0, WIDTH, "acc_step");
      do_op(2'b00, 4'h7, 4'h7, 1'b1, 0, "acc_add");
      acc_mode = 1'b0;
      do_op(2'b00, 4'h1, 4'h1, 1'b1, 0, "acc_clear");
`endif

      repeat (3) @(negedge clock);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
